imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, width of the instruction-memory word address; depth = 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all logic updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 in_valid  input  1  host byte-stream valid.
REQ-006 in_data  input  8  host byte-stream data.
REQ-007 in_ready  output  1  loader can accept a byte; transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-008 im_we  output  1  instruction-memory write enable, one cycle per word.
REQ-009 im_addr  output  ADDR_W  instruction-memory word address.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  holds the CPU in reset while 1.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  last session completed with a good checksum.
REQ-014 err  output  1  last session was aborted.

Function
REQ-015 The byte stream SHALL be formatted as follows:
- word count N: 16 bits, little-endian;
- N x 4 data bytes, each word little-endian (first byte -> bits 7:0);
- 1 checksum byte = XOR of all data bytes.
REQ-016 The FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR.
REQ-017 IDLE/DONE/ERR: start=1 -> LEN_LO.
- Running XOR, byte counter and word index cleared.
- done and err cleared.
REQ-018 start SHALL be ignored in LEN_LO, LEN_HI, DATA, WRITE and CHK.
REQ-019 in_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA and CHK; states advance only on an accepted byte.
REQ-020 LEN_HI accept: N=0 -> CHK; N > 2^ADDR_W -> ERR; otherwise -> DATA.
REQ-021 DATA SHALL shift each accepted byte into a 32-bit assembly register and XOR it into the checksum; the 4th byte -> WRITE.
REQ-022 WRITE SHALL last exactly one cycle, entered the cycle after the 4th byte is accepted, during which im_we=1, im_addr=word index and im_wdata=assembled word.
REQ-023 WRITE exit: word index increments (wraps within ADDR_W); -> CHK if index was N-1, else -> DATA.
REQ-024 CHK accept: byte equal to running XOR -> DONE; otherwise -> ERR.
REQ-025 im_we SHALL be 0 in every state other than WRITE; im_addr and im_wdata SHALL hold their last values outside WRITE.
REQ-026 Status outputs by state:
- busy = 1 in LEN_LO, LEN_HI, DATA, WRITE, CHK;
- done = 1 only in DONE;
- err = 1 only in ERR;
- cpu_hold = 0 only in DONE.
REQ-027 Gaps in in_valid SHALL stall the FSM with no state change and no loss of partial data.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE with these output values:
- im_we=0, im_addr=0, im_wdata=0;
- in_ready=0, busy=0, done=0, err=0;
- cpu_hold=1.
REQ-029 rst SHALL take priority over start and in_valid.
REQ-030 rst mid-session SHALL abort without any further im_we pulse.

Structure
REQ-031 The state encoding, the length field width (16) and the checksum width (8) SHALL reside in shared package imem_loader_pkg.
REQ-032 Byte-to-word assembly and byte counting SHALL be a sub-module named word_assembler, with clear, byte_valid, byte_in, word_out and word_full.

Verification
REQ-033 Good load: rst, start, bytes 02 00 11 22 33 44 AA BB CC DD 44 -> expected response:
- im_we at addr 0 = 0x44332211;
- im_we at addr 1 = 0xDDCCBBAA;
- then done=1, cpu_hold=0, err=0.
REQ-034 Bad checksum: same stream with last byte 45 -> two writes occur, then err=1, done=0, cpu_hold=1.
REQ-035 Empty load: bytes 00 00 00 -> done=1 with no im_we pulse; bytes 00 00 01 -> err=1.
REQ-036 Oversize (ADDR_W=8): bytes 01 01 -> err=1 immediately after LEN_HI accept, in_ready=0, no im_we.
REQ-037 Random in_valid gaps during a 3-word load -> identical writes to the gap-free run; start pulses while busy have no effect.
REQ-038 Reset and restart: rst during DATA of word 1 -> all outputs at reset values next cycle; a new full session then completes with done=1; start in DONE reasserts cpu_hold the next cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CHK_W  = 8;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_full flags the byte that completes a word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_full
);

  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_cnt;

  // Shift new bytes in at the top so the first byte ends up in bits 7:0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_word <= '0;
      r_cnt  <= 2'd0;
    end else if (byte_valid) begin
      r_word <= {byte_in, r_word[WORD_W-1:BYTE_W]};
      r_cnt  <= r_cnt + 2'd1;
    end else begin
      r_word <= r_word;
      r_cnt  <= r_cnt;
    end
  end

  assign word_out  = r_word;
  assign word_full = byte_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes it into instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(1) << ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic [CHK_W-1:0]  r_chk;
  logic [ADDR_W-1:0] r_widx;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [WORD_W-1:0] r_wdata_hold;

  logic              w_accept;
  logic              w_clear;
  logic              w_byte_valid;
  logic              w_word_full;
  logic [WORD_W-1:0] w_word;
  logic [LEN_W-1:0]  w_len_full;
  logic              w_oversize;
  logic              w_last;

  assign w_accept     = in_valid && in_ready;
  assign w_clear      = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_byte_valid = w_accept && (r_state == DATA);
  assign w_len_full   = {in_data, r_len[7:0]};
  assign w_oversize   = {1'b0, w_len_full} > DEPTH;
  assign w_last       = LEN_W'(r_widx) == (r_len - LEN_W'(1));

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_clear),
    .byte_valid (w_byte_valid),
    .byte_in    (in_data),
    .word_out   (w_word),
    .word_full  (w_word_full)
  );

  // Next-state and Moore status outputs.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    im_we    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (r_state)
      IDLE: begin
        if (start) w_next = LEN_LO;
        else       w_next = IDLE;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_next = LEN_HI;
        else          w_next = LEN_LO;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (!w_accept)              w_next = LEN_HI;
        else if (w_len_full == '0)  w_next = CHK;
        else if (w_oversize)        w_next = ERR;
        else                        w_next = DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_word_full) w_next = WRITE;
        else             w_next = DATA;
      end
      WRITE: begin
        im_we = 1'b1;
        busy  = 1'b1;
        if (w_last) w_next = CHK;
        else        w_next = DATA;
      end
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (!w_accept)             w_next = CHK;
        else if (in_data == r_chk) w_next = DONE;
        else                       w_next = ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) w_next = LEN_LO;
        else       w_next = DONE;
      end
      ERR: begin
        err = 1'b1;
        if (start) w_next = LEN_LO;
        else       w_next = ERR;
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory port shows the live word during WRITE and the last written values otherwise.
  assign im_addr  = (r_state == WRITE) ? r_widx : r_addr_hold;
  assign im_wdata = (r_state == WRITE) ? w_word : r_wdata_hold;

  // State register and session datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_chk        <= '0;
      r_widx       <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_len  <= '0;
        r_chk  <= '0;
        r_widx <= '0;
      end else begin
        case (r_state)
          LEN_LO: if (w_accept) r_len[7:0]  <= in_data;
          LEN_HI: if (w_accept) r_len[15:8] <= in_data;
          DATA:   if (w_accept) r_chk       <= chk_update(r_chk, in_data);
          WRITE: begin
            r_widx       <= r_widx + ADDR_W'(1);
            r_addr_hold  <= r_widx;
            r_wdata_hold <= w_word;
          end
          default: r_len <= r_len;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader: table of load sessions plus reset/restart sequences.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, im_we, cpu_hold, busy, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] cap_addr[$];
  logic [31:0]   cap_data[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (im_we) begin
      cap_addr.push_back(im_addr);
      cap_data.push_back(im_wdata);
    end
  end

  typedef struct {
    string        name;
    logic [127:0] stream;
    int           n;
    logic         e_done;
    logic         e_err;
    logic         e_hold;
    int           nw;
    logic [95:0]  wd;
    bit           gaps;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
    int waited;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h5A;
      start    = poke_start;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int g;
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    for (int i = 0; i < v.n; i++) begin
      g = v.gaps ? int'($urandom_range(0, 3)) : 0;
      send_byte(v.stream[127-8*i -: 8], g, v.gaps);
    end
    chk({v.name, ".done"}, 32'(done), 32'(v.e_done));
    chk({v.name, ".err"}, 32'(err), 32'(v.e_err));
    chk({v.name, ".cpu_hold"}, 32'(cpu_hold), 32'(v.e_hold));
    chk({v.name, ".busy"}, 32'(busy), 32'd0);
    chk({v.name, ".in_ready"}, 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk({v.name, ".nwrites"}, 32'(cap_addr.size()), 32'(v.nw));
    for (int k = 0; k < v.nw && k < cap_addr.size(); k++) begin
      chk($sformatf("%s.addr%0d", v.name, k), 32'(cap_addr[k]), 32'(k));
      chk($sformatf("%s.data%0d", v.name, k), cap_data[k], v.wd[32*k +: 32]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".im_we"}, 32'(im_we), 32'd0);
    chk({tag, ".im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, ".im_wdata"}, im_wdata, 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    int nw_before;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    vecs[0] = '{"good", 128'h02_00_11_22_33_44_AA_BB_CC_DD_44_00_00_00_00_00, 11,
                1'b1, 1'b0, 1'b0, 2, {32'h0, 32'hDDCCBBAA, 32'h44332211}, 1'b0};
    vecs[1] = '{"badchk", 128'h02_00_11_22_33_44_AA_BB_CC_DD_45_00_00_00_00_00, 11,
                1'b0, 1'b1, 1'b1, 2, {32'h0, 32'hDDCCBBAA, 32'h44332211}, 1'b0};
    vecs[2] = '{"empty_ok", 128'h00_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 3,
                1'b1, 1'b0, 1'b0, 0, 96'h0, 1'b0};
    vecs[3] = '{"empty_bad", 128'h00_00_01_00_00_00_00_00_00_00_00_00_00_00_00_00, 3,
                1'b0, 1'b1, 1'b1, 0, 96'h0, 1'b0};
    vecs[4] = '{"oversize", 128'h01_01_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 2,
                1'b0, 1'b1, 1'b1, 0, 96'h0, 1'b0};
    vecs[5] = '{"three_word", 128'h03_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0C_00, 15,
                1'b1, 1'b0, 1'b0, 3, {32'h0C0B0A09, 32'h08070605, 32'h04030201}, 1'b0};
    vecs[6] = '{"three_word_gaps", 128'h03_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0C_00, 15,
                1'b1, 1'b0, 1'b0, 3, {32'h0C0B0A09, 32'h08070605, 32'h04030201}, 1'b1};
    vecs[7] = '{"one_word", 128'h01_00_DE_AD_BE_EF_22_00_00_00_00_00_00_00_00_00, 7,
                1'b1, 1'b0, 1'b0, 1, {32'h0, 32'h0, 32'hEFBEADDE}, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    // Reset during DATA of word 1, then a full session, then restart from DONE.
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    nw_before = cap_addr.size();
    chk("midreset.pre_writes", 32'(nw_before), 32'd1);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset.no_more_writes", 32'(cap_addr.size()), 32'(nw_before));
    chk("midreset.idle_busy", 32'(busy), 32'd0);

    run_vec(vecs[0]);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("restart.done", 32'(done), 32'd0);
    chk("restart.busy", 32'(busy), 32'd1);
    chk("restart.in_ready", 32'(in_ready), 32'd1);
    chk("restart.addr_hold", 32'(im_addr), 32'd1);
    chk("restart.data_hold", im_wdata, 32'hDDCCBBAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
